// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
// Holds the FSM state encoding, saturating increment and stall-counter sizing.
package hls_deadlock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SUSPECT  = 2'd1,
      ST_DEADLOCK = 2'd2
   } dl_state_t;

   // Wide enough to hold 0..thresh so the stall counter can never wrap.
   function automatic int stall_cnt_width(input int thresh);
      return $clog2(thresh + 1);
   endfunction

   // Increment that sticks at the all-ones value of a width-bit field.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
      logic [31:0] max_v;
      if (width >= 32) begin
         max_v = 32'hFFFF_FFFF;
      end else begin
         max_v = (32'd1 << width) - 32'd1;
      end
      if (val >= max_v) begin
         return max_v;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/hls_deadlock_param_monitor_proc_stop.sv
// Per-process stop detection: qualifies owned AXIS stalls with the child
// monitor's block and folds in idle / FIFO-block status.
module hls_deadlock_proc_stop
   import hls_deadlock_pkg::*;
#(
   parameter int                N_AXIS = 4,
   parameter logic [N_AXIS-1:0] MAP    = {N_AXIS{1'b0}}
) (
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic              inst_idle,
   input  logic              inst_block,
   input  logic              sub_block,
   output logic              axis_qual,
   output logic              stop,
   output logic              stall
);

   logic owned_axis_s;

   assign owned_axis_s = |(axis_block_sigs & MAP);
   assign axis_qual    = sub_block & owned_axis_s;
   assign stop         = inst_idle | inst_block | axis_qual;
   assign stall        = inst_block | axis_qual;

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// Deadlock monitor for one HLS dataflow region: a stop condition must persist
// STALL_THRESH cycles before block is raised; snapshot and event count latch on entry.
module hls_deadlock_param_monitor
   import hls_deadlock_pkg::*;
#(
   parameter int                       N_PROC       = 7,
   parameter int                       N_AXIS       = 4,
   parameter logic [N_PROC*N_AXIS-1:0] AXIS_MAP     = {(N_PROC*N_AXIS){1'b0}},
   parameter int                       STALL_THRESH = 16,
   parameter int                       STICKY       = 1,
   parameter int                       CNT_W        = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic [N_PROC-1:0] inst_idle_sigs,
   input  logic [N_PROC-1:0] inst_block_sigs,
   input  logic [N_PROC-1:0] sub_block,
   output logic              block,
   output logic [N_PROC-1:0] stall_vec,
   output logic [CNT_W-1:0]  deadlock_cnt
);

   localparam int            CW       = stall_cnt_width(STALL_THRESH);
   localparam logic [CW-1:0] LAST_CNT = CW'(STALL_THRESH - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

   logic [N_PROC-1:0] axis_q_s;
   logic [N_PROC-1:0] stop_s;
   logic [N_PROC-1:0] stall_s;
   logic              all_stop_s;
   logic              has_axis_s;
   logic              cond_s;

   dl_state_t         state_r;
   dl_state_t         state_nxt_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nxt_s;
   logic              enter_dl_s;
   logic              leave_dl_s;

   logic              block_r;
   logic [N_PROC-1:0] stall_vec_r;
   logic [CNT_W-1:0]  deadlock_cnt_r;

   for (genvar p = 0; p < N_PROC; p++) begin : g_proc
      hls_deadlock_proc_stop #(
         .N_AXIS (N_AXIS),
         .MAP    (AXIS_MAP[p*N_AXIS +: N_AXIS])
      ) u_stop (
         .axis_block_sigs (axis_block_sigs),
         .inst_idle       (inst_idle_sigs[p]),
         .inst_block      (inst_block_sigs[p]),
         .sub_block       (sub_block[p]),
         .axis_qual       (axis_q_s[p]),
         .stop            (stop_s[p]),
         .stall           (stall_s[p])
      );
   end

   // An all-idle region is not a deadlock: at least one AXIS stall must be present.
   assign all_stop_s = &stop_s;
   assign has_axis_s = |axis_q_s;
   assign cond_s     = enable & all_stop_s & has_axis_s;

   // Next-state and stall-counter logic; disabling the monitor always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = ZERO_CNT;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cond_s) begin
                  if (STALL_THRESH == 1) begin
                     state_nxt_s = ST_DEADLOCK;
                     cnt_nxt_s   = ZERO_CNT;
                  end else begin
                     state_nxt_s = ST_SUSPECT;
                     cnt_nxt_s   = ONE_CNT;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = ZERO_CNT;
               end
            end
            ST_SUSPECT: begin
               if (!cond_s) begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = ZERO_CNT;
               end else if (cnt_r == LAST_CNT) begin
                  state_nxt_s = ST_DEADLOCK;
                  cnt_nxt_s   = ZERO_CNT;
               end else begin
                  state_nxt_s = ST_SUSPECT;
                  cnt_nxt_s   = cnt_r + ONE_CNT;
               end
            end
            ST_DEADLOCK: begin
               cnt_nxt_s = ZERO_CNT;
               // A sticky declaration ignores the live condition; only clear releases it.
               if (STICKY != 0) begin
                  if (clear) begin
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_DEADLOCK;
                  end
               end else begin
                  if (clear || !cond_s) begin
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_DEADLOCK;
                  end
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = ZERO_CNT;
            end
         endcase
      end
   end

   assign enter_dl_s = (state_nxt_s == ST_DEADLOCK) && (state_r != ST_DEADLOCK);
   assign leave_dl_s = (state_r == ST_DEADLOCK) && (state_nxt_s != ST_DEADLOCK);

   // State, counter and registered outputs; snapshot and event count update on entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         cnt_r          <= ZERO_CNT;
         block_r        <= 1'b0;
         stall_vec_r    <= {N_PROC{1'b0}};
         deadlock_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         block_r <= (state_nxt_s == ST_DEADLOCK);
         if (enter_dl_s) begin
            stall_vec_r    <= stall_s;
            deadlock_cnt_r <= CNT_W'(sat_inc(32'(deadlock_cnt_r), CNT_W));
         end else if (leave_dl_s) begin
            stall_vec_r    <= {N_PROC{1'b0}};
         end else begin
            stall_vec_r    <= stall_vec_r;
         end
      end
   end

   assign block        = block_r;
   assign stall_vec    = stall_vec_r;
   assign deadlock_cnt = deadlock_cnt_r;

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Randomised scoreboard bench: a run-length reference model predicts the outputs of a
// sticky 16-cycle monitor and a non-sticky 3-cycle, 2-bit-counter monitor on shared inputs.
module tb_hls_deadlock_param_monitor;

   localparam logic [27:0] TB_MAP = 28'h800_0070; // proc1 owns axis0..2, proc6 owns axis3

   logic       clock;
   logic       reset;
   logic       enable;
   logic       clear;
   logic [3:0] axis_block_sigs;
   logic [6:0] inst_idle_sigs;
   logic [6:0] inst_block_sigs;
   logic [6:0] sub_block;

   logic       block_a;
   logic [6:0] stall_vec_a;
   logic [7:0] deadlock_cnt_a;
   logic       block_b;
   logic [6:0] stall_vec_b;
   logic [1:0] deadlock_cnt_b;

   hls_deadlock_param_monitor #(
      .N_PROC(7), .N_AXIS(4), .AXIS_MAP(TB_MAP), .STALL_THRESH(16), .STICKY(1), .CNT_W(8)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
      .block(block_a), .stall_vec(stall_vec_a), .deadlock_cnt(deadlock_cnt_a)
   );

   hls_deadlock_param_monitor #(
      .N_PROC(7), .N_AXIS(4), .AXIS_MAP(TB_MAP), .STALL_THRESH(3), .STICKY(0), .CNT_W(2)
   ) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .sub_block(sub_block),
      .block(block_b), .stall_vec(stall_vec_b), .deadlock_cnt(deadlock_cnt_b)
   );

   typedef struct {
      logic       b0;
      logic [6:0] s0;
      logic [7:0] c0;
      logic       b1;
      logic [6:0] s1;
      logic [1:0] c1;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int         thr_c[2]    = '{16, 3};
   bit         sticky_c[2] = '{1'b1, 1'b0};
   int         cmax_c[2]   = '{255, 3};
   int         run_m[2];
   bit         blk_m[2];
   logic [6:0] snap_m[2];
   int         cnt_m[2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         run_m[i] = 0; blk_m[i] = 1'b0; snap_m[i] = 7'd0; cnt_m[i] = 0;
      end
   endtask

   // Reference: count consecutive qualifying cycles; declare once the run reaches the threshold.
   task automatic model_step();
      bit         all_stop = 1'b1;
      bit         has_axis = 1'b0;
      bit         cond;
      logic [6:0] stall = 7'd0;
      exp_t       e;
      for (int p = 0; p < 7; p++) begin
         bit owned = 1'b0;
         bit ax;
         for (int a = 0; a < 4; a++)
            if (TB_MAP[p*4+a] && axis_block_sigs[a]) owned = 1'b1;
         ax = sub_block[p] && owned;
         if (!(inst_idle_sigs[p] || inst_block_sigs[p] || ax)) all_stop = 1'b0;
         if (ax) has_axis = 1'b1;
         stall[p] = inst_block_sigs[p] | ax;
      end
      cond = enable && all_stop && has_axis;
      for (int i = 0; i < 2; i++) begin
         if (!enable) begin
            run_m[i] = 0; blk_m[i] = 1'b0; snap_m[i] = 7'd0;
         end else if (blk_m[i]) begin
            if (clear || (!sticky_c[i] && !cond)) begin
               run_m[i] = 0; blk_m[i] = 1'b0; snap_m[i] = 7'd0;
            end
         end else if (cond) begin
            run_m[i]++;
            if (run_m[i] >= thr_c[i]) begin
               blk_m[i] = 1'b1; snap_m[i] = stall; run_m[i] = 0;
               if (cnt_m[i] < cmax_c[i]) cnt_m[i]++;
            end
         end else begin
            run_m[i] = 0;
         end
      end
      e.b0 = blk_m[0]; e.s0 = snap_m[0]; e.c0 = 8'(cnt_m[0]);
      e.b1 = blk_m[1]; e.s1 = snap_m[1]; e.c1 = 2'(cnt_m[1]);
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clock);
         model_step();
         #1;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_block_a"}, 32'(block_a), 32'd0);
      check({tag, "_stall_a"}, 32'(stall_vec_a), 32'd0);
      check({tag, "_cnt_a"}, 32'(deadlock_cnt_a), 32'd0);
      check({tag, "_block_b"}, 32'(block_b), 32'd0);
      check({tag, "_stall_b"}, 32'(stall_vec_b), 32'd0);
      check({tag, "_cnt_b"}, 32'(deadlock_cnt_b), 32'd0);
   endtask

   // Reset lands between edges so the outputs must clear without any clock.
   task automatic async_reset(input string tag);
      @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_zero_outputs(tag);
      model_reset();
      #1;
      reset = 1'b1;
   endtask

   task automatic set_stall1();
      enable = 1'b1; clear = 1'b0;
      inst_idle_sigs = 7'b1111101; inst_block_sigs = 7'd0;
      axis_block_sigs = 4'b0001; sub_block = 7'h7F;
   endtask

   // Monitor: every cycle the DUTs present outputs; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("block_a", 32'(block_a), 32'(e.b0));
            check("stall_vec_a", 32'(stall_vec_a), 32'(e.s0));
            check("deadlock_cnt_a", 32'(deadlock_cnt_a), 32'(e.c0));
            check("block_b", 32'(block_b), 32'(e.b1));
            check("stall_vec_b", 32'(stall_vec_b), 32'(e.s1));
            check("deadlock_cnt_b", 32'(deadlock_cnt_b), 32'(e.c1));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0;
      axis_block_sigs = 4'd0; inst_idle_sigs = 7'd0; inst_block_sigs = 7'd0; sub_block = 7'd0;
      model_reset();
      #1 reset = 1'b0;
      #2 check_zero_outputs("reset");
      #19 reset = 1'b1;

      // Basic declaration, hold, then sticky release by clear.
      set_stall1();
      run(20);
      axis_block_sigs = 4'd0;
      run(4);
      clear = 1'b1; run(1);
      clear = 1'b0; run(3);

      // Stall broken after 9 cycles: full restart required.
      set_stall1(); run(9);
      axis_block_sigs = 4'd0; run(1);
      set_stall1(); run(15);
      run(2);

      // Clear together with cond while declared: re-detection from the next cycle.
      clear = 1'b1; run(1);
      clear = 1'b0; run(17);

      // All idle, no AXIS stall: never a deadlock.
      clear = 1'b1; inst_idle_sigs = 7'h7F; axis_block_sigs = 4'd0; run(1);
      clear = 1'b0; run(100);

      // Disable during deadlock drops block but keeps the count.
      set_stall1(); run(17);
      enable = 1'b0; run(2);
      enable = 1'b1; run(18);

      // Asynchronous reset mid-suspect and while declared.
      async_reset("rst_suspect");
      set_stall1(); run(8);
      async_reset("rst_suspect8");
      run(17);
      async_reset("rst_deadlock");

      // Saturation of the 2-bit counter over repeated declare/clear rounds.
      for (int k = 0; k < 5; k++) begin
         set_stall1(); run(16);
         axis_block_sigs = 4'd0; clear = 1'b1; run(1);
         clear = 1'b0; run(1);
      end

      // Randomised segments biased towards all-stop patterns.
      for (int s = 0; s < 70; s++) begin
         int len;
         len = $urandom_range(1, 24);
         enable = ($urandom_range(0, 15) != 0);
         inst_idle_sigs  = 7'($urandom) | 7'($urandom) | 7'($urandom);
         inst_block_sigs = 7'($urandom) & 7'($urandom);
         axis_block_sigs = 4'($urandom);
         sub_block = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
         if ($urandom_range(0, 5) == 0) begin
            clear = 1'b1; run(1);
         end
         clear = 1'b0;
         run(len);
      end

      repeat (2) @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
